dvs_spike_scheduler: RTL and testbench
======================================

# dvs_spike_scheduler

Sequences DVS camera events into the event-to-RAVENS spike converter (`dvs_event_to_ravens_spike`) and onto the RAVENS input link. Incoming events are buffered in a FIFO that can never backpressure the camera. The FIFO head is converted to a spike packet and released over a valid/ready handshake. Spikes are grouped into fixed-length timestep windows derived from event timestamps, and the block pulses `step_done` at each window boundary so the downstream RAVENS driver can advance network time.

## Interface
- `FIFO_DEPTH`, default 16: event FIFO entries; power of two, ≥2.
- `WINDOW_US`, default 1000: timestep window length in µs; range 1 to 2^DVS_TS_BITS−1.
- Package constants used: EVENT_BITS, DVS_X_ADDR_BITS, DVS_Y_ADDR_BITS, DVS_TS_BITS, DVS_WIDTH_PXLS, RAVENS_PKT_BITS.
- Event layout is {x, y, polarity, ts}, MSB first; ts is the low DVS_TS_BITS bits.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  admit new events when high.
- `evt_valid`  in  1  camera event present.
- `evt_ready`  out  1  equals `enable` once out of reset. Never deasserted because the FIFO is full.
- `evt_data`  in  EVENT_BITS  DVS event.
- `spk_valid`  out  1  spike packet valid.
- `spk_ready`  in  1  downstream accepts the packet.
- `spk_data`  out  RAVENS_PKT_BITS  converter output for the FIFO head.
- `step_done`  out  1  one-cycle pulse when a window closes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `drop_count`  out  16  count of events dropped on overflow; saturates at 0xFFFF.

## Operation
- **Push:** on `evt_valid && evt_ready`, the event is written if the FIFO is not full. Otherwise it is discarded and `drop_count` increments.
- **Full test:** fullness is evaluated before a same-cycle pop, so a push into a full FIFO is dropped even if the FIFO pops that cycle.
- **Conversion:** the FIFO head feeds a `dvs_event_to_ravens_spike` instance. `spk_data` is combinational from the registered head entry and is stable while the head is unchanged.
- **Window state:** `win_active` (1 bit) and `win_start` (DVS_TS_BITS). `age = (head_ts − win_start) mod 2^DVS_TS_BITS`, so timestamp wrap-around is handled naturally.
- **IDLE** (FIFO empty):
  - `spk_valid` = 0.
  - Go to EMIT when the FIFO becomes non-empty.
- **EMIT:**
  - If `!win_active`: `win_start` ← head_ts and `win_active` ← 1; the head is treated as in-window this cycle.
  - If `win_active && age ≥ WINDOW_US`: `spk_valid` = 0 and go to STEP.
  - Otherwise `spk_valid` = 1. On `spk_ready`, pop the head; go to IDLE if that pop empties the FIFO.
- **STEP** (exactly one cycle):
  - `step_done` = 1 and `spk_valid` = 0.
  - `win_start` ← head_ts. Intermediate empty windows are collapsed and produce no extra pulses.
  - Return to EMIT.
- **`enable` = 0:** only blocks pushes. The FIFO continues to drain and windows continue to close.
- **Reset:**
  - All outputs are 0, the FIFO is empty, `drop_count` = 0, `win_active` = 0, state is IDLE.
  - A mid-operation reset asynchronously discards queued events and any offered spike.

## Timing
- An event pushed in cycle N is at the head in N+1. `spk_valid` rises in N+1 if the event is in-window, or in N+2 if a STEP cycle intervenes.
- Throughput is one spike per cycle while `spk_ready` = 1.
- `spk_valid` holds and `spk_data` stays constant until `spk_ready`. `spk_valid` never drops without a handshake, except on reset.
- `fifo_level` and `drop_count` update in the cycle after the push or pop.
- `step_done` is never asserted in the same cycle as `spk_valid`.

## Configuration
- `DVS_SCHED_DEDUP_EN` defined:
  - Adds a 256-bit fired bitmap indexed by the 8-bit neuron field {core, neuron}.
  - In EMIT, if the head's bit is already set, the head is popped with `spk_valid` = 0 (1 cycle, no handshake).
  - Otherwise the bit is set on the spike handshake.
  - The bitmap is cleared in STEP and on reset.
- Undefined: no bitmap, and every in-window event emits a spike.

## Test plan
- **Reset:** assert `rst` mid-stream with 5 events queued → all outputs 0 immediately and `fifo_level` = 0; after release, `evt_ready` = `enable`.
- **Single event:** x=3, y=2, ts=10, `spk_ready`=1 → `spk_valid` one cycle after push; `spk_data` = {3'b0, 16'b0, (3+2·DVS_WIDTH_PXLS)%256, 5'b0}.
- **Window boundary:** WINDOW_US=1000, events at ts 0, 500, 1000 → spike, spike, one-cycle `step_done`, then spike; ts 2500 next → one more `step_done` only.
- **Overflow:** FIFO_DEPTH=16, 20 back-to-back events with `spk_ready`=0 → `fifo_level`=16, `drop_count`=4, `evt_ready` stays 1; then `spk_ready`=1 → 16 spikes in 16 consecutive cycles.
- **Timestamp wrap:** ts = 2^DVS_TS_BITS−100, then ts = 200 (age 300) → no `step_done`, two spikes.
- **Dedup:** same pixel twice at ts 0 and 10 → one spike with `DVS_SCHED_DEDUP_EN`, two without; same pixel again at ts 1200 → a spike in both builds.

Source files
------------

// File: rtl/dvs_spike_scheduler.sv
// DVS event scheduler: event FIFO, timestep windowing and spike handshake toward RAVENS.
// Optional per-window duplicate-neuron suppression is enabled by defining DVS_SCHED_DEDUP_EN.

package dvs_pkg;
    localparam int DVS_X_ADDR_BITS = 8;
    localparam int DVS_Y_ADDR_BITS = 8;
    localparam int DVS_TS_BITS     = 16;
    localparam int DVS_WIDTH_PXLS  = 240;
    localparam int EVENT_BITS      = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + DVS_TS_BITS;
    localparam int RAVENS_PKT_BITS = 32;
    localparam int RAVENS_NID_LSB  = 5;
endpackage

module dvs_event_to_ravens_spike
    import dvs_pkg::*;
(
    input  logic [EVENT_BITS-1:0]      evt,
    output logic [RAVENS_PKT_BITS-1:0] pkt
);
    logic [DVS_X_ADDR_BITS-1:0] x;
    logic [DVS_Y_ADDR_BITS-1:0] y;
    logic                       pol;
    logic [DVS_TS_BITS-1:0]     ts;
    logic [31:0]                lin;
    logic                       unused_bits;

    assign {x, y, pol, ts} = evt;
    assign lin = 32'(x) + 32'(y) * 32'(DVS_WIDTH_PXLS);
    // {type, reserved, core/neuron, reserved}; the neuron field is the linear pixel index mod 256
    assign pkt = {3'b000, 16'h0000, lin[7:0], 5'b00000};
    assign unused_bits = ^{pol, ts, lin[31:8]};
endmodule

module dvs_spike_scheduler
    import dvs_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WINDOW_US  = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            evt_valid,
    output logic                            evt_ready,
    input  logic [EVENT_BITS-1:0]           evt_data,
    output logic                            spk_valid,
    input  logic                            spk_ready,
    output logic [RAVENS_PKT_BITS-1:0]      spk_data,
    output logic                            step_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [DVS_TS_BITS-1:0] WIN = DVS_TS_BITS'(WINDOW_US);

    // Handshake: a spike transfers on a rising edge where spk_valid && spk_ready;
    // once raised, spk_valid and spk_data hold until that transfer.
    typedef enum logic [1:0] {IDLE, EMIT, STEP} state_t;
    state_t state;

    logic [EVENT_BITS-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]              rd_ptr, wr_ptr, rd_ptr_nx;
    logic [LW-1:0]              level, level_nx;
    logic                       win_active, rst_done;
    logic [DVS_TS_BITS-1:0]     win_start, head_ts, age;
    logic [DVS_TS_BITS-1:0]     ws_nx, next_ts, next_age;
    logic                       wa_nx, expired, next_expired;
    logic                       emit_ok, dup, pop, full, accept, push;
    logic [RAVENS_PKT_BITS-1:0] head_pkt;

    dvs_event_to_ravens_spike u_conv (.evt(mem[rd_ptr]), .pkt(head_pkt));

    assign head_ts   = mem[rd_ptr][DVS_TS_BITS-1:0];
    assign age       = head_ts - win_start;
    assign expired   = win_active && (age >= WIN);
    assign emit_ok   = (state == EMIT) && !expired;
    assign spk_valid = emit_ok && !dup;
    assign pop       = emit_ok && (dup || spk_ready);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign evt_ready = enable && rst_done;
    assign accept    = evt_valid && evt_ready;
    assign push      = accept && !full;
    assign level_nx  = level + LW'(push) - LW'(pop);
    assign spk_data  = (level != '0) ? head_pkt : '0;
    assign fifo_level = level;

    // Look ahead at the entry that becomes head next cycle so a window close
    // is decided at the edge it arrives, not one cycle later.
    assign rd_ptr_nx    = rd_ptr + PW'(1);
    assign next_ts      = (pop && (level > LW'(1))) ? mem[rd_ptr_nx][DVS_TS_BITS-1:0]
                                                    : evt_data[DVS_TS_BITS-1:0];
    assign ws_nx        = ((state == EMIT) && !win_active) ? head_ts : win_start;
    assign wa_nx        = win_active || (state == EMIT);
    assign next_age     = next_ts - ws_nx;
    assign next_expired = wa_nx && (next_age >= WIN);

`ifdef DVS_SCHED_DEDUP_EN
    logic [255:0] fired;
    logic [7:0]   head_nid;

    assign head_nid = head_pkt[RAVENS_NID_LSB +: 8];
    assign dup      = (state == EMIT) && fired[head_nid];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fired <= '0;
        end else if (state == STEP) begin
            fired <= '0;
        end else if (spk_valid && spk_ready) begin
            fired[head_nid] <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            win_active <= 1'b0;
            win_start  <= '0;
            drop_count <= '0;
            step_done  <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            rst_done  <= 1'b1;
            step_done <= 1'b0;
            level     <= level_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;
            if (accept && full && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            case (state)
                IDLE: begin
                    if (push) begin
                        state     <= next_expired ? STEP : EMIT;
                        step_done <= next_expired;
                    end
                end
                EMIT: begin
                    if (!win_active) begin
                        win_start  <= head_ts;
                        win_active <= 1'b1;
                    end
                    if (expired) begin
                        state     <= STEP;
                        step_done <= 1'b1;
                    end else if (pop) begin
                        if (level_nx == '0) begin
                            state <= IDLE;
                        end else if (next_expired) begin
                            state     <= STEP;
                            step_done <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    win_start <= head_ts;
                    state     <= EMIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dvs_spike_scheduler.sv
// Self-checking bench for dvs_spike_scheduler: spike/step token scoreboard plus directed checks.
module tb_dvs_spike_scheduler;
    import dvs_pkg::*;

    localparam int WIN = 1000;
    localparam logic [RAVENS_PKT_BITS:0] STEP_TOK = {1'b1, 32'h0};

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       enable = 1'b1;
    logic                       evt_valid = 1'b0;
    logic                       spk_ready = 1'b0;
    logic [EVENT_BITS-1:0]      evt_data = '0;
    logic                       evt_ready, spk_valid, step_done;
    logic [RAVENS_PKT_BITS-1:0] spk_data;
    logic [4:0]                 fifo_level;
    logic [15:0]                drop_count;

    int checks = 0;
    int errors = 0;
    logic [RAVENS_PKT_BITS:0] exp_q[$];
    logic [RAVENS_PKT_BITS:0] obs_tok, exp_tok;

    dvs_spike_scheduler #(.FIFO_DEPTH(16), .WINDOW_US(WIN)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data),
        .step_done(step_done), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EVENT_BITS-1:0] mk_evt(input int x, input int y, input int ts, input int pol);
        logic [7:0]  xb;
        logic [7:0]  yb;
        logic [15:0] tb;
        logic        pb;
        xb = 8'(x); yb = 8'(y); tb = 16'(ts); pb = 1'(pol);
        return {xb, yb, pb, tb};
    endfunction

    function automatic logic [RAVENS_PKT_BITS:0] spike_tok(input int x, input int y);
        int         idx;
        logic [7:0] ib;
        idx = (x + y * DVS_WIDTH_PXLS) % 256;
        ib  = 8'(idx);
        return {1'b0, 3'b000, 16'h0000, ib, 5'b00000};
    endfunction

    // Scoreboard: every step pulse and every spike handshake is one ordered token.
    always @(negedge clk) begin
        if (!rst) begin
            if (step_done) begin
                checks++;
                if (spk_valid) begin
                    errors++;
                    $display("FAIL step_overlap: spk_valid=%0b with step_done=1, required 0", spk_valid);
                end
            end
            if (step_done || (spk_valid && spk_ready)) begin
                obs_tok = step_done ? STEP_TOK : {1'b0, spk_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_token: got %h, none expected", obs_tok);
                end else begin
                    exp_tok = exp_q.pop_front();
                    if (obs_tok !== exp_tok) begin
                        errors++;
                        $display("FAIL token_order: got %h, required %h", obs_tok, exp_tok);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        evt_valid = 1'b0;
        spk_ready = 1'b0;
        enable = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int ts);
        evt_data = mk_evt(x, y, ts, 0);
        evt_valid = 1'b1;
        @(posedge clk);
        #1 evt_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d tokens outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spk_valid, step_done, fifo_level, drop_count, evt_ready} !== {1'b0, 1'b0, 5'd0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle: valid=%0b step=%0b level=%0d drops=%0d ready=%0b, required 0 0 0 0 1",
                     spk_valid, step_done, fifo_level, drop_count, evt_ready);
        end
        for (int i = 0; i < 5; i++) send(i, 0, 100);
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++;
            $display("FAIL reset_fill_level: got %0d, required 5", fifo_level);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({spk_valid, spk_data, step_done, fifo_level, drop_count, evt_ready} !== '0) begin
            errors++;
            $display("FAIL reset_async_outputs: valid=%0b data=%h step=%0b level=%0d drops=%0d ready=%0b, required all 0",
                     spk_valid, spk_data, step_done, fifo_level, drop_count, evt_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b1 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b level=%0d, required 1 0", evt_ready, fifo_level);
        end
        enable = 1'b0;
        #1;
        checks++;
        if (evt_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_follows_enable: got %0b, required 0", evt_ready);
        end
        enable = 1'b1;
    endtask

    task automatic test_single();
        logic [RAVENS_PKT_BITS-1:0] want;
        do_reset();
        spk_ready = 1'b1;
        want = {3'b000, 16'h0000, 8'((3 + 2 * DVS_WIDTH_PXLS) % 256), 5'b00000};
        exp_q.push_back(spike_tok(3, 2));
        send(3, 2, 10);
        @(negedge clk);
        checks++;
        if (spk_valid !== 1'b1 || spk_data !== want) begin
            errors++;
            $display("FAIL single_latency: valid=%0b data=%h, required 1 %h", spk_valid, spk_data, want);
        end
        wait_drain("single");
    endtask

    task automatic test_window();
        do_reset();
        spk_ready = 1'b1;
        exp_q.push_back(spike_tok(1, 0)); send(1, 0, 0);   wait_drain("win_0");
        exp_q.push_back(spike_tok(2, 0)); send(2, 0, 500); wait_drain("win_500");
        exp_q.push_back(STEP_TOK);
        exp_q.push_back(spike_tok(3, 0));
        send(3, 0, 1000);
        @(negedge clk);
        checks++;
        if (step_done !== 1'b1 || spk_valid !== 1'b0) begin
            errors++;
            $display("FAIL window_step_cycle: step=%0b valid=%0b, required 1 0", step_done, spk_valid);
        end
        @(negedge clk);
        checks++;
        if (step_done !== 1'b0 || spk_valid !== 1'b1) begin
            errors++;
            $display("FAIL window_after_step: step=%0b valid=%0b, required 0 1", step_done, spk_valid);
        end
        wait_drain("win_1000");
        exp_q.push_back(STEP_TOK);
        exp_q.push_back(spike_tok(4, 0));
        send(4, 0, 2500);
        wait_drain("win_2500");
    endtask

    task automatic test_overflow();
        int ready_low;
        int run;
        do_reset();
        ready_low = 0;
        for (int i = 0; i < 20; i++) begin
            evt_data = mk_evt(i + 10, 0, 300, i % 2);
            evt_valid = 1'b1;
            if (i < 16) exp_q.push_back(spike_tok(i + 10, 0));
            @(negedge clk);
            if (evt_ready !== 1'b1) ready_low++;
            @(posedge clk);
            #1;
        end
        evt_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd16 || drop_count !== 16'd4 || ready_low != 0) begin
            errors++;
            $display("FAIL overflow_fill: level=%0d drops=%0d ready_low_cycles=%0d, required 16 4 0",
                     fifo_level, drop_count, ready_low);
        end
        // Push into the full FIFO in the same cycle as the first pop: must still drop.
        @(posedge clk);
        #1;
        spk_ready = 1'b1;
        evt_data = mk_evt(99, 0, 300, 0);
        evt_valid = 1'b1;
        run = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) evt_valid = 1'b0;
            if (spk_valid) run++;
            else break;
        end
        checks++;
        if (run != 16) begin
            errors++;
            $display("FAIL overflow_burst: %0d consecutive spikes, required 16", run);
        end
        wait_drain("overflow");
        checks++;
        if (drop_count !== 16'd5) begin
            errors++;
            $display("FAIL overflow_full_pop_drop: drops=%0d, required 5", drop_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        spk_ready = 1'b1;
        exp_q.push_back(spike_tok(5, 0)); send(5, 0, 65536 - 100); wait_drain("wrap_a");
        exp_q.push_back(spike_tok(6, 0)); send(6, 0, 200);         wait_drain("wrap_b");
    endtask

    task automatic test_dedup();
        do_reset();
        spk_ready = 1'b1;
        exp_q.push_back(spike_tok(7, 1)); send(7, 1, 0); wait_drain("dedup_a");
`ifndef DVS_SCHED_DEDUP_EN
        exp_q.push_back(spike_tok(7, 1));
`endif
        send(7, 1, 10);
        wait_drain("dedup_b");
        exp_q.push_back(STEP_TOK);
        exp_q.push_back(spike_tok(7, 1));
        send(7, 1, 1200);
        wait_drain("dedup_c");
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        evt_data = mk_evt(20, 0, 50, 0);
        evt_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 evt_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL enable_blocks_push: level=%0d drops=%0d, required 0 0", fifo_level, drop_count);
        end
        enable = 1'b1;
        exp_q.push_back(spike_tok(20, 0)); send(20, 0, 50);
        exp_q.push_back(spike_tok(21, 0)); send(21, 0, 60);
        enable = 1'b0;
        spk_ready = 1'b1;
        wait_drain("enable_drain");
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL enable_drain_level: got %0d, required 0", fifo_level);
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit           active;
        int           start, ts, x, y, idx;
        bit [255:0]   fired;
        do_reset();
        active = 0; start = 0; ts = 0; fired = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            spk_ready = ($urandom_range(0, 3) != 0);
            if (fifo_level < 12 && $urandom_range(0, 1) == 1) begin
                x  = $urandom_range(0, 5);
                y  = $urandom_range(0, 2);
                ts = (ts + $urandom_range(0, 450)) % 65536;
                evt_data = mk_evt(x, y, ts, $urandom_range(0, 1));
                evt_valid = 1'b1;
                if (!active) begin
                    active = 1; start = ts;
                end else if (((ts - start) & 32'hFFFF) >= WIN) begin
                    exp_q.push_back(STEP_TOK);
                    start = ts;
                    fired = '0;
                end
                idx = (x + y * DVS_WIDTH_PXLS) % 256;
`ifdef DVS_SCHED_DEDUP_EN
                if (!fired[idx]) begin
                    exp_q.push_back(spike_tok(x, y));
                    fired[idx] = 1'b1;
                end
`else
                exp_q.push_back(spike_tok(x, y));
`endif
            end else begin
                evt_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        evt_valid = 1'b0;
        spk_ready = 1'b1;
        wait_drain("random");
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL random_drops: got %0d, required 0", drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_window();
        test_overflow();
        test_wrap();
        test_dedup();
        test_enable();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
